// File: rtl/my_div_pkg.sv
// Shared types and constants for the signed iterative divider.
package my_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/my_div_step.sv
// One non-restoring step: adds or subtracts the zero-extended divisor
// from a WIDTH+1-bit partial remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sub,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] d_ext;
    logic [WIDTH:0] operand;

    assign d_ext    = {1'b0, divisor};
    // Subtraction is invert-plus-one, with the +1 fed as the carry-in term.
    assign operand  = sub ? ~d_ext : d_ext;
    assign rem_next = rem + operand + {{WIDTH{1'b0}}, sub};
    assign q_bit    = ~rem_next[WIDTH];

endmodule

// File: rtl/my_div.sv
// Signed WIDTH-bit divider: magnitudes go through WIDTH non-restoring
// steps, then a fix-up cycle restores the remainder and applies signs.
module my_div
    import my_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic             sign_n;
    logic             sign_q;
    logic             ovf_pend;

    logic [WIDTH:0]   step_rem_in;
    logic             step_sub;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] r_mag;

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        neg = ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        mag = x[WIDTH-1] ? neg(x) : x;
    endfunction

    // The same adder performs the final add-back of the divisor in FIX.
    assign step_rem_in = (state == FIX) ? p : {p[WIDTH-1:0], q[WIDTH-1]};
    assign step_sub    = (state == FIX) ? 1'b0 : ~p[WIDTH];
    assign r_mag       = p[WIDTH] ? step_rem[WIDTH-1:0] : p[WIDTH-1:0];
    assign dbg_state   = state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (step_rem_in),
        .divisor  (b),
        .sub      (step_sub),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            p         <= '0;
            q         <= '0;
            b         <= '0;
            sign_n    <= 1'b0;
            sign_q    <= 1'b0;
            ovf_pend  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        p        <= '0;
                        q        <= mag(dividend);
                        b        <= mag(divisor);
                        sign_n   <= dividend[WIDTH-1];
                        sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        ovf_pend <= (dividend == MIN_VAL) && (divisor == '1);
                        dbz      <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            dbz       <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                            state     <= DONE;
                        end else begin
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    p   <= step_rem;
                    q   <= {q[WIDTH-2:0], step_q};
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= sign_q ? neg(q) : q;
                    remainder <= sign_n ? neg(r_mag) : r_mag;
                    ovf       <= ovf_pend;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_div.sv
// Bench for my_div: directed sign/zero/overflow/reset cases and a random
// sweep, checked against a longint arithmetic reference.
module tb_my_div;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_V = 32'h8000_0000;
    localparam logic [W-1:0] MAX_V = 32'h7FFF_FFFF;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;
    logic [1:0]   dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [65:0] exp_q[$];

    my_div #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {dbz, ovf, quotient, remainder} from plain signed arithmetic.
    function automatic logic [65:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, qq, rr;
        logic   dz, ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            qq = 0;
            rr = 0;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            if (qq > ((longint'(1) << (W - 1)) - 1)) ov = 1'b1;
        end
        return {dz, ov, qq[W-1:0], rr[W-1:0]};
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_quotient"}, quotient, 0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dbz"}, dbz, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
        logic [65:0] e;
        int cycles;
        int lat;
        exp_q.push_back(ref_div(a, b));
        lat = (b == '0) ? 1 : W + 2;
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1 start = 1'b0;
        cycles = 0;
        forever begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (done) break;
            check("busy_during", busy, 1);
            if (cycles >= 100) begin
                check("done_timeout", 0, 1);
                break;
            end
            if (junk) begin
                start    = 1'($urandom_range(0, 1));
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check("latency", cycles, lat);
        check("quotient", quotient, e[63:32]);
        check("remainder", remainder, e[31:0]);
        check("dbz", dbz, e[65]);
        check("ovf", ovf, e[64]);
        check("busy_at_done", busy, 0);
        @(negedge clock);
        check("done_once", done, 0);
        check("quotient_hold", quotient, e[63:32]);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges [8];
        edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, MIN_V, MAX_V, 32'd2, 32'hFFFF_FFFE, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
        if ($urandom_range(0, 2) == 0) return W'($signed(16'($urandom)));
        return $urandom;
    endfunction

    initial begin
        int done_seen;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #23;
        check_idle_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        run_div(32'd100, 32'd7, 1'b1);
        run_div(-32'sd100, 32'd7, 1'b1);
        run_div(32'd100, -32'sd7, 1'b0);
        run_div(32'd12345, 32'd0, 1'b0);
        run_div(MIN_V, 32'hFFFF_FFFF, 1'b0);

        // Start, ignored restart at cycle 10, reset at cycle 20.
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        check("busy_after_restart", busy, 1);
        repeat (9) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_idle_zero("midop_reset");
        @(negedge clock);
        check_idle_zero("held_reset");
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        check("no_done_after_reset", done_seen, 0);
        run_div(32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            run_div(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
